shape_processor_cfg_master: RTL

//  Bus initiator that programs the shape processor CTRL SFR on behalf of a host.
//  - Takes (shape, operation) requests over a valid/ready handshake.
//  - Drives the write/write_data strobe, then reads CTRL back over read/read_data.
//  - Returns the readback with a pass/fail verdict over a second valid/ready handshake.
//  - Sits between the host sequencer and the shape processor SFR port; keeps

---
 rtl/shape_processor_cfg_master_if.sv | 31 +++
 rtl/shape_processor_cfg_master.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/shape_processor_cfg_master_if.sv
// Host request/response handshakes plus the shape processor SFR port,
// bundled for the configuration master (master) and its peers (slave).
interface shape_processor_cfg_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_shape;
  logic [4:0]  req_operation;
  logic        write;
  logic [31:0] write_data;
  logic        read;
  logic [31:0] read_data;
  logic        error;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_ok;
  logic        rsp_error;
  logic        rsp_illegal;
  logic [31:0] rsp_ctrl;

  modport master (
    input  req_valid, req_shape, req_operation, read_data, error, rsp_ready,
    output req_ready, write, write_data, read, rsp_valid, rsp_ok, rsp_error,
    rsp_illegal, rsp_ctrl
  );

  modport slave (
    output req_valid, req_shape, req_operation, read_data, error, rsp_ready,
    input  req_ready, write, write_data, read, rsp_valid, rsp_ok, rsp_error,
    rsp_illegal, rsp_ctrl
  );
endinterface

// File: rtl/shape_processor_cfg_master.sv
// Programs the shape processor CTRL SFR from host requests, reads it back and
// returns a verdict with saturating pass/reject statistics.
module shape_processor_cfg_master #(
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned SKIP_ILLEGAL = 0,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    shape_processor_cfg_master_if.master  bus,
    output logic [CNT_W-1:0]              cnt_ok,
    output logic [CNT_W-1:0]              cnt_rej
);

    localparam logic [1:0] SHAPE_RECT   = 2'b01;
    localparam logic [1:0] SHAPE_TRI    = 2'b10;
    localparam logic [4:0] OP_PERIMETER = 5'b00000;
    localparam logic [4:0] OP_AREA      = 5'b00001;
    localparam logic [4:0] OP_IS_SQUARE = 5'b01000;
    localparam logic [4:0] OP_IS_EQUI   = 5'b10000;
    localparam logic [4:0] OP_IS_ISOS   = 5'b10001;
    localparam logic [1:0] LAT          = 2'(READ_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_READ,
        S_RWAIT,
        S_RESP
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  shape_q;
    logic [4:0]  op_q;
    logic        illegal_q;
    logic        skipped_q;
    logic        err_flag;
    logic [31:0] ctrl_q;
    logic [1:0]  lat_cnt;
    logic        accept;
    logic        req_legal;
    logic        match_ok;

    function automatic logic is_legal(input logic [1:0] shape, input logic [4:0] op);
        logic rect, tri_s;
        rect  = (shape == SHAPE_RECT);
        tri_s = (shape == SHAPE_TRI);
        case (op)
            OP_PERIMETER, OP_AREA: is_legal = rect || tri_s;
            OP_IS_SQUARE:          is_legal = rect;
            OP_IS_EQUI, OP_IS_ISOS: is_legal = tri_s;
            default:               is_legal = 1'b0;
        endcase
    endfunction

    assign accept    = bus.req_valid && (state == S_IDLE);
    assign req_legal = is_legal(bus.req_shape, bus.req_operation);
    // A skipped request has nothing to compare against, so it can never pass.
    assign match_ok  = !err_flag && !skipped_q &&
                       (ctrl_q[17:16] == shape_q) && (ctrl_q[4:0] == op_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx        = state;
        bus.req_ready   = 1'b0;
        bus.write       = 1'b0;
        bus.write_data  = '0;
        bus.read        = 1'b0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_ok      = 1'b0;
        bus.rsp_error   = 1'b0;
        bus.rsp_illegal = 1'b0;
        bus.rsp_ctrl    = ctrl_q;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (accept)
                    state_nx = ((SKIP_ILLEGAL != 0) && !req_legal) ? S_RESP : S_WRITE;
            end
            S_WRITE: begin
                bus.write      = 1'b1;
                bus.write_data = {14'b0, shape_q, 11'b0, op_q};
                state_nx       = S_GAP;
            end
            S_GAP: state_nx = S_READ;
            S_READ: begin
                bus.read = 1'b1;
                state_nx = (READ_LATENCY == 0) ? S_RESP : S_RWAIT;
            end
            S_RWAIT: if (lat_cnt == LAT) state_nx = S_RESP;
            S_RESP: begin
                bus.rsp_valid   = 1'b1;
                bus.rsp_ok      = match_ok;
                bus.rsp_error   = err_flag;
                bus.rsp_illegal = illegal_q;
                if (bus.rsp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shape_q   <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            skipped_q <= 1'b0;
            err_flag  <= 1'b0;
            ctrl_q    <= '0;
            lat_cnt   <= '0;
            cnt_ok    <= '0;
            cnt_rej   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    err_flag <= 1'b0;
                    if (accept) begin
                        shape_q   <= bus.req_shape;
                        op_q      <= bus.req_operation;
                        illegal_q <= !req_legal;
                        skipped_q <= (SKIP_ILLEGAL != 0) && !req_legal;
                        ctrl_q    <= '0;
                    end
                end
                S_WRITE, S_GAP: if (bus.error) err_flag <= 1'b1;
                S_READ: begin
                    lat_cnt <= 2'd1;
                    if (READ_LATENCY == 0) ctrl_q <= bus.read_data;
                end
                S_RWAIT: begin
                    lat_cnt <= lat_cnt + 2'd1;
                    if (lat_cnt == LAT) ctrl_q <= bus.read_data;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        if (match_ok) begin
                            if (cnt_ok != '1) cnt_ok <= cnt_ok + 1'b1;
                        end else begin
                            if (cnt_rej != '1) cnt_rej <= cnt_rej + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
